// File: rtl/ow_byte_ctrl_if.sv
// Command/response and sockit_owm bus bundle for the byte-level 1-wire engine.
// master = upstream FSM plus owm port side, slave = ow_byte_ctrl.
interface ow_byte_ctrl_if #(
    parameter int BWD = 32
);
    logic           i_cmd_valid;
    logic           o_cmd_ready;
    logic [1:0]     i_cmd;
    logic [7:0]     i_cmd_data;
    logic           o_rsp_valid;
    logic [7:0]     o_rsp_data;
    logic           o_rsp_presence;
    logic           o_rsp_timeout;
    logic [7:0]     o_crc;
    logic           o_bus_ren;
    logic           o_bus_wen;
    logic           o_bus_adr;
    logic [BWD-1:0] o_bus_wdt;
    logic [BWD-1:0] i_bus_rdt;

    modport master (
        output i_cmd_valid, i_cmd, i_cmd_data, i_bus_rdt,
        input  o_cmd_ready, o_rsp_valid, o_rsp_data,
        input  o_rsp_presence, o_rsp_timeout, o_crc,
        input  o_bus_ren, o_bus_wen, o_bus_adr, o_bus_wdt
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_cmd_data, i_bus_rdt,
        output o_cmd_ready, o_rsp_valid, o_rsp_data,
        output o_rsp_presence, o_rsp_timeout, o_crc,
        output o_bus_ren, o_bus_wen, o_bus_adr, o_bus_wdt
    );
endinterface

// File: rtl/ow_byte_ctrl.sv
// Byte-level 1-wire command engine driving sockit_owm bit cycles via CTRL.
// Define OW_CRC8_EN to build the running Dallas CRC8 on o_crc.
module ow_byte_ctrl #(
    parameter int BWD     = 32,
    parameter int TMO_W   = 20,
    parameter int TMO_CYC = 1000000
) (
    input logic       i_clk,
    input logic       i_rst,
    ow_byte_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_POLL  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [1:0] C_RST = 2'd0;
    localparam logic [1:0] C_WR  = 2'd1;
    localparam logic [1:0] C_RD  = 2'd2;
    localparam logic [1:0] C_RSV = 2'd3;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [2:0]       state;
    logic [1:0]       cmd;
    logic [7:0]       sh;
    logic [2:0]       bit_idx;
    logic             busy_seen;
    logic             pres;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       rsp_data;
    logic             rsp_pres;
    logic             rsp_tmo;
    logic [7:0]       crc;

    logic       ready;
    logic       accept;
    logic       cyc;
    logic       dat;
    logic       bit_end;
    logic       tmo_hit;
    logic       wr_bit;
    logic [3:0] wdt_lo;
    logic       unused_rdt;

    assign cyc     = bus.i_bus_rdt[3];
    assign dat     = bus.i_bus_rdt[0];
    assign ready   = (state == S_IDLE) && !i_rst;
    assign accept  = bus.i_cmd_valid && ready;
    assign bit_end = (state == S_POLL) && busy_seen && !cyc;
    assign tmo_hit = (state == S_POLL) && !bit_end
                     && (tmo_cnt == TMO_LAST);
    assign wr_bit  = sh[bit_idx];

    assign unused_rdt = ^{bus.i_bus_rdt[BWD-1:4], bus.i_bus_rdt[2:1]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            cmd       <= C_RST;
            sh        <= 8'h00;
            bit_idx   <= 3'd0;
            busy_seen <= 1'b0;
            pres      <= 1'b0;
            tmo_cnt   <= '0;
            rsp_data  <= 8'h00;
            rsp_pres  <= 1'b0;
            rsp_tmo   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd     <= bus.i_cmd;
                        sh      <= (bus.i_cmd == C_WR) ? bus.i_cmd_data : 8'h00;
                        bit_idx <= 3'd0;
                        pres    <= 1'b0;
                        if (bus.i_cmd == C_RSV) begin
                            rsp_data <= 8'h00;
                            rsp_pres <= 1'b0;
                            rsp_tmo  <= 1'b0;
                            state    <= S_RESP;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    tmo_cnt   <= '0;
                    busy_seen <= 1'b0;
                    state     <= S_POLL;
                end
                S_POLL: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (cyc) busy_seen <= 1'b1;
                    if (bit_end) begin
                        if (cmd == C_RST) pres <= ~dat;
                        if (cmd == C_RD) sh <= {dat, sh[7:1]};
                        state <= S_NEXT;
                    end else if (tmo_hit) begin
                        // partial data is discarded on abort
                        rsp_data <= 8'h00;
                        rsp_pres <= 1'b0;
                        rsp_tmo  <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_NEXT: begin
                    if (cmd == C_RST || bit_idx == 3'd7) begin
                        rsp_data <= (cmd == C_RD) ? sh : 8'h00;
                        rsp_pres <= (cmd == C_RST) && pres;
                        rsp_tmo  <= 1'b0;
                        state    <= S_RESP;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        state   <= S_ISSUE;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        wdt_lo = 4'h0;
        if (state == S_ISSUE) begin
            unique case (1'b1)
                cmd == C_RST: wdt_lo = 4'hA;
                cmd == C_WR:  wdt_lo = {3'b100, wr_bit};
                default:      wdt_lo = 4'h9;
            endcase
        end
    end

`ifdef OW_CRC8_EN
    logic cur_bit;
    logic crc_fb;

    assign cur_bit = (cmd == C_RD) ? dat : wr_bit;
    assign crc_fb  = crc[0] ^ cur_bit;

    // reflected 0x31 polynomial, one data bit per completed owm cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            crc <= 8'h00;
        end else if (accept && bus.i_cmd == C_RST) begin
            crc <= 8'h00;
        end else if (bit_end && cmd != C_RST) begin
            crc <= {1'b0, crc[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
        end
    end
`else
    assign crc = 8'h00;
`endif

    assign bus.o_cmd_ready    = ready;
    assign bus.o_rsp_valid    = (state == S_RESP) && !i_rst;
    assign bus.o_rsp_data     = rsp_data;
    assign bus.o_rsp_presence = rsp_pres;
    assign bus.o_rsp_timeout  = rsp_tmo;
    assign bus.o_crc          = crc;
    assign bus.o_bus_wen      = (state == S_ISSUE) && !i_rst;
    assign bus.o_bus_ren      = (state == S_POLL) && !i_rst;
    assign bus.o_bus_adr      = 1'b0;
    assign bus.o_bus_wdt      = {{(BWD-4){1'b0}}, wdt_lo};
endmodule
